// File: rtl/fb_scaler_pkg.sv
// Shared types and helper functions for the framebuffer upscaler: RGB type,
// fixed colour-index expansion and window/size helpers used at elaboration.
package fb_scaler_pkg;

   typedef logic [23:0] rgb24_t;

   function automatic int unsigned win_end(input int unsigned offset,
                                           input int unsigned src,
                                           input int unsigned scale);
      return offset + src * scale;
   endfunction

   function automatic int unsigned frame_pixels(input int unsigned w,
                                                input int unsigned h);
      return w * h;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Three or more index bits drive R,G,B as on/off channels; narrower
   // indices become a grey ramp by replicating the index across the byte.
   function automatic rgb24_t fixed_expand(input logic [7:0] idx,
                                           input int unsigned pix_bits);
      rgb24_t     c;
      logic [7:0] g;
      c = '0;
      g = '0;
      if (pix_bits >= 3) begin
         c = {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
      end else begin
         for (int i = 0; i < 8; i++) begin
            g[3'(7 - i)] = idx[3'(pix_bits - 1 - (i % pix_bits))];
         end
         c = {g, g, g};
      end
      return c;
   endfunction

endpackage

// File: rtl/fb_palette.sv
// Runtime-writable colour lookup table: one write port, one registered read
// port; entries reset to the fixed expansion of their own index.
module fb_palette
   import fb_scaler_pkg::*;
#(
   parameter int unsigned PIX_BITS = 3
) (
   input  logic                clk_pixel,
   input  logic                resetn,
   input  logic                we,
   input  logic [PIX_BITS-1:0] wr_idx,
   input  rgb24_t              wr_rgb,
   input  logic [PIX_BITS-1:0] rd_idx,
   output rgb24_t              rd_rgb
);

   localparam int unsigned ENTRIES = 1 << PIX_BITS;

   rgb24_t entry_reg [ENTRIES];
   rgb24_t rd_rgb_reg;

   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entry_reg[i] <= fixed_expand(8'(i), PIX_BITS);
         end
      end else if (we) begin
         entry_reg[wr_idx] <= wr_rgb;
      end
   end

   // A read of the entry being written in the same cycle returns the old value.
   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         rd_rgb_reg <= '0;
      end else begin
         rd_rgb_reg <= entry_reg[rd_idx];
      end
   end

   assign rd_rgb = rd_rgb_reg;

endmodule

// File: rtl/fb_scaler.sv
// Integer-scaled, offset window upscaler: turns the hdmi scan position into
// source memory addresses and the returned colour index into 24-bit RGB.
module fb_scaler
   import fb_scaler_pkg::*;
#(
   parameter int unsigned SRC_W       = 160,
   parameter int unsigned SRC_H       = 120,
   parameter int unsigned SCALE_X     = 4,
   parameter int unsigned SCALE_Y     = 4,
   parameter int unsigned OFFSET_X    = 0,
   parameter int unsigned OFFSET_Y    = 0,
   parameter int unsigned PIX_BITS    = 3,
   parameter int unsigned CX_BITS     = 10,
   parameter int unsigned ADDR_BITS   = 15,
   parameter int unsigned MEM_LATENCY = 1,
   parameter rgb24_t      BORDER_RGB  = 24'h000000
) (
   input  logic                 clk_pixel,
   input  logic                 resetn,
   input  logic                 enable,
   input  logic                 palette_mode,
   input  logic [CX_BITS-1:0]   cx,
   input  logic [CX_BITS-1:0]   cy,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_en,
   input  logic [PIX_BITS-1:0]  mem_data,
   input  logic                 pal_we,
   input  logic [PIX_BITS-1:0]  pal_idx,
   input  logic [23:0]          pal_rgb,
   output logic [23:0]          rgb,
   output logic                 active
);

   localparam int unsigned WIN_W = win_end(OFFSET_X, SRC_W, SCALE_X) - OFFSET_X;
   localparam int unsigned WIN_H = win_end(OFFSET_Y, SRC_H, SCALE_Y) - OFFSET_Y;
   localparam int unsigned SXW   = cnt_width(SCALE_X);
   localparam int unsigned SYW   = cnt_width(SCALE_Y);

   localparam logic [SXW-1:0]       SUB_X_LAST = SXW'(SCALE_X - 1);
   localparam logic [SYW-1:0]       SUB_Y_LAST = SYW'(SCALE_Y - 1);
   localparam logic [ADDR_BITS-1:0] ROW_STEP   = ADDR_BITS'(SRC_W);

   // Window test by unsigned wrap: positions left of/above the window wrap
   // to huge values and fail the single upper-bound compare.
   logic [31:0] rel_x;
   logic [31:0] rel_y;
   logic        in_win;
   logic        last_col;
   logic        frame_start;

   assign rel_x       = 32'(cx) - OFFSET_X;
   assign rel_y       = 32'(cy) - OFFSET_Y;
   assign in_win      = (rel_x < WIN_W) && (rel_y < WIN_H);
   assign last_col    = (rel_x == WIN_W - 1);
   assign frame_start = (cx == '0) && (cy == '0);

   logic [SXW-1:0]       sub_x_reg,    sub_x_next,    cur_sub_x;
   logic [SYW-1:0]       sub_y_reg,    sub_y_next,    cur_sub_y;
   logic [ADDR_BITS-1:0] addr_reg,     addr_next,     cur_addr;
   logic [ADDR_BITS-1:0] row_base_reg, row_base_next, cur_row_base;
   logic                 sync_reg;
   logic                 mode_reg;
   logic                 cur_sync;
   logic                 cur_mode;

   // Frame start clears the counters for the current pixel itself, so an
   // in-window (0,0) is addressed as 0 and advances from there.
   always_comb begin
      cur_sub_x    = frame_start ? '0 : sub_x_reg;
      cur_sub_y    = frame_start ? '0 : sub_y_reg;
      cur_addr     = frame_start ? '0 : addr_reg;
      cur_row_base = frame_start ? '0 : row_base_reg;
      cur_sync     = sync_reg | frame_start;
      cur_mode     = frame_start ? palette_mode : mode_reg;
   end

   always_comb begin
      sub_x_next    = cur_sub_x;
      sub_y_next    = cur_sub_y;
      addr_next     = cur_addr;
      row_base_next = cur_row_base;
      if (in_win) begin
         if (last_col) begin
            sub_x_next = '0;
            if (cur_sub_y != SUB_Y_LAST) begin
               sub_y_next = cur_sub_y + 1'b1;
               addr_next  = cur_row_base;
            end else begin
               sub_y_next    = '0;
               row_base_next = cur_row_base + ROW_STEP;
               addr_next     = cur_row_base + ROW_STEP;
            end
         end else if (cur_sub_x == SUB_X_LAST) begin
            sub_x_next = '0;
            addr_next  = cur_addr + 1'b1;
         end else begin
            sub_x_next = cur_sub_x + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         sub_x_reg    <= '0;
         sub_y_reg    <= '0;
         addr_reg     <= '0;
         row_base_reg <= '0;
         sync_reg     <= 1'b0;
         mode_reg     <= 1'b0;
      end else begin
         sub_x_reg    <= sub_x_next;
         sub_y_reg    <= sub_y_next;
         addr_reg     <= addr_next;
         row_base_reg <= row_base_next;
         sync_reg     <= cur_sync;
         mode_reg     <= cur_mode;
      end
   end

   // Stage 1: memory request; the mode travels with the pixel so a frame
   // boundary never recolours pixels of the previous frame.
   logic [ADDR_BITS-1:0] mem_addr_reg;
   logic                 mem_en_reg;
   logic                 req_mode_reg;

   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         mem_addr_reg <= '0;
         mem_en_reg   <= 1'b0;
         req_mode_reg <= 1'b0;
      end else begin
         mem_addr_reg <= cur_addr;
         mem_en_reg   <= enable & in_win & cur_sync;
         req_mode_reg <= cur_mode;
      end
   end

   assign mem_addr = mem_addr_reg;
   assign mem_en   = mem_en_reg;

   // Delay line matching the memory read latency.
   logic [MEM_LATENCY-1:0] win_pipe_reg;
   logic [MEM_LATENCY-1:0] mode_pipe_reg;

   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         win_pipe_reg  <= '0;
         mode_pipe_reg <= '0;
      end else begin
         win_pipe_reg  <= MEM_LATENCY'({win_pipe_reg, mem_en_reg});
         mode_pipe_reg <= MEM_LATENCY'({mode_pipe_reg, req_mode_reg});
      end
   end

   // Output stage: palette read and fixed expansion registered in parallel.
   rgb24_t pal_rgb_q;
   rgb24_t fixed_reg;
   logic   active_reg;
   logic   pal_sel_reg;

   fb_palette #(
      .PIX_BITS (PIX_BITS)
   ) u_palette (
      .clk_pixel (clk_pixel),
      .resetn    (resetn),
      .we        (pal_we),
      .wr_idx    (pal_idx),
      .wr_rgb    (pal_rgb),
      .rd_idx    (mem_data),
      .rd_rgb    (pal_rgb_q)
   );

   always_ff @(posedge clk_pixel or negedge resetn) begin
      if (!resetn) begin
         fixed_reg   <= '0;
         active_reg  <= 1'b0;
         pal_sel_reg <= 1'b0;
      end else begin
         fixed_reg   <= fixed_expand(8'(mem_data), PIX_BITS);
         active_reg  <= win_pipe_reg[MEM_LATENCY-1];
         pal_sel_reg <= mode_pipe_reg[MEM_LATENCY-1];
      end
   end

   assign active = active_reg;
   assign rgb    = active_reg ? (pal_sel_reg ? pal_rgb_q : fixed_reg) : BORDER_RGB;

endmodule
